alu_seq: RTL

Sequencer that owns the ALU's control inputs and its side of the shared data bus. It accepts one arithmetic request at a time over a valid/ready handshake and loads both operands through the tri-state bus buffer. It issues the compute op, captures the ALU's bus result and returns it over a second valid/ready handshake. It sits between the instruction-level control and the `alu` + `tri_buf` pair; no other agent drives `alu.op` or the controller's `tri_buf`.

---
 rtl/alu_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequencer that owns the ALU control inputs and the controller side
// of the shared data bus. One request at a time: latch operands, load R0 and
// R1 through the bus buffer, issue the compute op, capture the bus result and
// hold it until the consumer takes it.
//
// Optional feature macro: ALU_SEQ_OPERAND_CACHE_EN
//   defined   -> remember the last R0/R1 values and skip redundant loads
//   undefined -> every request performs both loads (fixed 4-cycle latency)
//
// Op encoding on req_op/alu_op (3 bits):
//   0 NOP, 1 WRITE_R0, 2 WRITE_R1, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [2:0]       alu_op,
  output logic             bus_rw,
  output logic [WIDTH-1:0] bus_data,
  input  logic [WIDTH-1:0] bus
);

  localparam logic [2:0] ALU_NOP      = 3'd0;
  localparam logic [2:0] ALU_WRITE_R0 = 3'd1;
  localparam logic [2:0] ALU_WRITE_R1 = 3'd2;

  typedef enum logic [2:0] {IDLE, LOAD_R0, LOAD_R1, EXEC, RESP} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;

  // Anything that is not a NOP or a register write produces a bus result.
  logic compute_req;
  logic compute_reg;
  assign compute_req = (req_op != ALU_NOP) && (req_op != ALU_WRITE_R0) && (req_op != ALU_WRITE_R1);
  assign compute_reg = (op_reg != ALU_NOP) && (op_reg != ALU_WRITE_R0) && (op_reg != ALU_WRITE_R1);

  logic hit0_req;
  logic hit1_req;
  logic hit1_reg;

`ifdef ALU_SEQ_OPERAND_CACHE_EN
  logic [WIDTH-1:0] r0_cache_reg;
  logic [WIDTH-1:0] r1_cache_reg;
  logic             r0_valid_reg;
  logic             r1_valid_reg;

  // A hit means the ALU register already holds the wanted operand.
  assign hit0_req = r0_valid_reg && (req_a == r0_cache_reg);
  assign hit1_req = r1_valid_reg && (req_b == r1_cache_reg);
  // LOAD_R0 never touches R1, so the R1 decision can be re-made from b_reg.
  assign hit1_reg = r1_valid_reg && (b_reg == r1_cache_reg);

  // Track what was last written into R0/R1; a non-compute request voids both.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r0_cache_reg <= '0;
      r1_cache_reg <= '0;
      r0_valid_reg <= 1'b0;
      r1_valid_reg <= 1'b0;
    end else begin
      if (state_reg == LOAD_R0) begin
        r0_cache_reg <= a_reg;
        r0_valid_reg <= 1'b1;
      end
      if (state_reg == LOAD_R1) begin
        r1_cache_reg <= b_reg;
        r1_valid_reg <= 1'b1;
      end
      if ((state_reg == EXEC) && !compute_reg) begin
        r0_valid_reg <= 1'b0;
        r1_valid_reg <= 1'b0;
      end
    end
  end
`else
  assign hit0_req = 1'b0;
  assign hit1_req = 1'b0;
  assign hit1_reg = 1'b0;
`endif

  // Control FSM; every output is registered with the value for the next state.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= ALU_NOP;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_op    <= ALU_NOP;
      bus_rw    <= 1'b0;
      bus_data  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            a_reg     <= req_a;
            b_reg     <= req_b;
            op_reg    <= req_op;
            req_ready <= 1'b0;
            if (!hit0_req) begin
              state_reg <= LOAD_R0;
              alu_op    <= ALU_WRITE_R0;
              bus_rw    <= 1'b1;
              bus_data  <= req_a;
            end else if (!hit1_req) begin
              state_reg <= LOAD_R1;
              alu_op    <= ALU_WRITE_R1;
              bus_rw    <= 1'b1;
              bus_data  <= req_b;
            end else begin
              state_reg <= EXEC;
              alu_op    <= compute_req ? req_op : ALU_NOP;
            end
          end
        end
        LOAD_R0: begin
          if (!hit1_reg) begin
            state_reg <= LOAD_R1;
            alu_op    <= ALU_WRITE_R1;
            bus_rw    <= 1'b1;
            bus_data  <= b_reg;
          end else begin
            state_reg <= EXEC;
            alu_op    <= compute_reg ? op_reg : ALU_NOP;
            bus_rw    <= 1'b0;
            bus_data  <= '0;
          end
        end
        LOAD_R1: begin
          state_reg <= EXEC;
          alu_op    <= compute_reg ? op_reg : ALU_NOP;
          bus_rw    <= 1'b0;
          bus_data  <= '0;
        end
        EXEC: begin
          state_reg <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= compute_reg ? bus : '0;
          rsp_err   <= !compute_reg;
          alu_op    <= ALU_NOP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          alu_op    <= ALU_NOP;
          bus_rw    <= 1'b0;
          bus_data  <= '0;
        end
      endcase
    end
  end

endmodule
